// File: rtl/fetch_stage.sv
// fetch_stage: Thumb instruction fetch for the Cortex-M0 pipeline.
// Fetches 32-bit words, splits them into halfwords in a small prefetch FIFO
// and drives the IF/ID register consumed by decode and hazard detection.
// Optional build macro FETCH_PERF_EN enables the flush/stall perf counters;
// without it both counter ports are tied to zero.
module fetch_stage #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int          BUF_DEPTH    = 4,
   parameter logic [15:0] NOP_INSTR    = 16'hBF00
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic [31:0] branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        if_id_valid,
   output logic [15:0] if_id_instr,
   output logic [31:0] if_id_pc,
   output logic [31:0] flush_count,
   output logic [31:0] stall_cycles
);
   localparam int PTR_W = $clog2(BUF_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_WAIT = 1'b1;

   logic [0:0]       r_state;
   logic             r_drop;
   logic [31:0]      r_fetch_ptr;
   logic             r_skip_lo;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic [15:0]      r_buf_instr [BUF_DEPTH];
   logic [31:0]      r_buf_pc    [BUF_DEPTH];
   logic             r_valid;
   logic [15:0]      r_instr;
   logic [31:0]      r_pc;

   logic [CNT_W-1:0] w_free;
   logic             w_req;
   logic             w_accept;
   logic             w_pop;
   logic [1:0]       w_npush;
   logic [PTR_W-1:0] w_wr_nx;
   logic [31:0]      w_pc_hi;
   logic             w_unused;

   // Halfword addressing: bit 0 of the branch target carries no information.
   assign w_unused = branch_target[0];

   assign w_free   = DEPTH_C - r_count;
   // A request only issues when both halfwords of the reply are guaranteed room.
   assign w_req    = !rst && (r_state == S_IDLE) && !flush && (w_free >= CNT_W'(2));
   // Live data: outstanding, not marked stale, not discarded by a same-cycle flush.
   assign w_accept = imem_rvalid && (r_state == S_WAIT) && !r_drop && !flush;
   assign w_pop    = (r_count != '0) && !stall && !flush;
   assign w_npush  = !w_accept ? 2'd0 : (r_skip_lo ? 2'd1 : 2'd2);
   assign w_wr_nx  = r_wr_ptr + PTR_W'(1);
   assign w_pc_hi  = r_fetch_ptr + 32'd2;

   assign imem_req  = w_req;
   assign imem_addr = {r_fetch_ptr[31:2], 2'b00};

   // Write returned halfwords into FIFO storage, each tagged with its PC.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         if (r_skip_lo) begin
            r_buf_instr[r_wr_ptr] <= imem_rdata[31:16];
            r_buf_pc[r_wr_ptr]    <= w_pc_hi;
         end else begin
            r_buf_instr[r_wr_ptr] <= imem_rdata[15:0];
            r_buf_pc[r_wr_ptr]    <= r_fetch_ptr;
            r_buf_instr[w_wr_nx]  <= imem_rdata[31:16];
            r_buf_pc[w_wr_nx]     <= w_pc_hi;
         end
      end
   end

   // Request FSM, fetch pointer and FIFO bookkeeping; flush redirects and
   // marks any in-flight reply stale unless it lands in the flush cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_drop      <= 1'b0;
         r_fetch_ptr <= {RESET_VECTOR[31:2], 2'b00};
         r_skip_lo   <= RESET_VECTOR[1];
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
      end else if (flush) begin
         r_fetch_ptr <= {branch_target[31:2], 2'b00};
         r_skip_lo   <= branch_target[1];
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         if (r_state == S_WAIT) begin
            if (imem_rvalid) begin
               r_state <= S_IDLE;
               r_drop  <= 1'b0;
            end else begin
               r_drop  <= 1'b1;
            end
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_req) r_state <= S_WAIT;
            end
            default: begin
               if (imem_rvalid) begin
                  r_state <= S_IDLE;
                  r_drop  <= 1'b0;
                  if (!r_drop) begin
                     r_fetch_ptr <= r_fetch_ptr + 32'd4;
                     r_skip_lo   <= 1'b0;
                  end
               end
            end
         endcase
         r_wr_ptr <= r_wr_ptr + PTR_W'(w_npush);
         r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop);
         r_count  <= r_count + CNT_W'(w_npush) - CNT_W'(w_pop);
      end
   end

   // IF/ID register: flush inserts a NOP, stall holds, otherwise pop or bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_instr <= NOP_INSTR;
         r_pc    <= 32'h0;
      end else if (flush) begin
         r_valid <= 1'b0;
         r_instr <= NOP_INSTR;
      end else if (!stall) begin
         if (r_count != '0) begin
            r_valid <= 1'b1;
            r_instr <= r_buf_instr[r_rd_ptr];
            r_pc    <= r_buf_pc[r_rd_ptr];
         end else begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
         end
      end
   end

   assign if_id_valid = r_valid;
   assign if_id_instr = r_instr;
   assign if_id_pc    = r_pc;

`ifdef FETCH_PERF_EN
   logic [31:0] r_flush_count;
   logic [31:0] r_stall_cycles;

   // Performance counters: flush cycles and stall-only cycles, free-running wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_flush_count  <= 32'h0;
         r_stall_cycles <= 32'h0;
      end else if (flush) begin
         r_flush_count  <= r_flush_count + 32'd1;
      end else if (stall) begin
         r_stall_cycles <= r_stall_cycles + 32'd1;
      end
   end

   assign flush_count  = r_flush_count;
   assign stall_cycles = r_stall_cycles;
`else
   assign flush_count  = 32'h0;
   assign stall_cycles = 32'h0;
`endif

endmodule
